// File: rtl/gcd_pkg.sv
// Shared definitions for the subtraction-based GCD engine.
// Holds the default operand width and the FSM state encodings.
// States are plain localparam constants so older tools that lack enum
// support can still read the state register directly.
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/gcd_datapath.sv
// GCD datapath: working a/b registers, comparison flags and the subtractor.
// The controller either loads fresh operands or requests one reduction step.
// A step always subtracts the smaller value from the larger one, so the
// registers never underflow.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_val,
    output logic [WIDTH-1:0] b_val,
    output logic             a_zero,
    output logic             b_zero,
    output logic             eq,
    output logic             gt
);

    // Comparator flags the controller uses to choose between finishing and stepping
    always_comb begin
        a_zero = (a_val == '0);
        b_zero = (b_val == '0);
        eq     = (a_val == b_val);
        gt     = (a_val > b_val);
    end

    // Working registers: capture operands on load, otherwise reduce the larger one
    always_ff @(posedge clk) begin
        if (reset) begin
            a_val <= '0;
            b_val <= '0;
        end else if (load) begin
            a_val <= a_in;
            b_val <= b_in;
        end else if (step) begin
            if (gt) begin
                a_val <= a_val - b_val;
            end else begin
                b_val <= b_val - a_val;
            end
        end
    end

endmodule

// File: rtl/gcd_top.sv
// Top level of the iterative GCD engine.
// Contains the IDLE/CALC/DONE controller, the registered Result and done outputs,
// and the optional CALC-cycle counter enabled by defining GCD_CYCLE_COUNT_EN.
// Result only changes when an operation completes; a reset mid-operation
// discards the work in progress.
module gcd_top
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             done
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [WIDTH-1:0] cycles
`endif
);

    logic [1:0]       state;
    logic             load;
    logic             step;
    logic             finish_calc;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;
    logic             a_zero;
    logic             b_zero;
    logic             eq;
    logic             gt;

    gcd_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .a_in  (A),
        .b_in  (B),
        .a_val (a_val),
        .b_val (b_val),
        .a_zero(a_zero),
        .b_zero(b_zero),
        .eq    (eq),
        .gt    (gt)
    );

    // Decode controller strobes: operands load only in IDLE, a CALC cycle either finishes or steps
    always_comb begin
        load        = (state == ST_IDLE) && start;
        finish_calc = (state == ST_CALC) && (a_zero || b_zero || eq);
        step        = (state == ST_CALC) && !finish_calc;
    end

    // Controller: IDLE waits for start, CALC runs until terminal, DONE lasts one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start)       state <= ST_CALC;
                ST_CALC: if (finish_calc) state <= ST_DONE;
                ST_DONE:                  state <= ST_IDLE;
                default:                  state <= ST_IDLE;
            endcase
        end
    end

    // Publish the GCD on completion; a zero a means the answer sits in b, otherwise in a
    always_ff @(posedge clk) begin
        if (reset) begin
            Result <= '0;
            done   <= 1'b0;
        end else begin
            done <= finish_calc;
            if (finish_calc) begin
                Result <= a_zero ? b_val : a_val;
            end
        end
    end

`ifdef GCD_CYCLE_COUNT_EN
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] calc_cnt;
    logic [WIDTH-1:0] calc_cnt_inc;

    // Saturating increment so very long operations report all-ones instead of wrapping
    always_comb begin
        calc_cnt_inc = (&calc_cnt) ? calc_cnt : calc_cnt + CNT_ONE;
    end

    // Count CALC cycles of the running operation and publish the total alongside Result
    always_ff @(posedge clk) begin
        if (reset) begin
            calc_cnt <= '0;
            cycles   <= '0;
        end else if (load) begin
            calc_cnt <= '0;
        end else if (state == ST_CALC) begin
            calc_cnt <= calc_cnt_inc;
            if (finish_calc) begin
                cycles <= calc_cnt_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gcd_top.sv
// Directed testbench for gcd_top.
// Walks through hand-computed GCD vectors with start held high, checks exact
// completion latency, the done pulse, Result holding, zero operands, the
// worst-case operand pair, operand changes during CALC and reset mid-operation.
module tb_gcd_top;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic             done;
`ifdef GCD_CYCLE_COUNT_EN
    logic [WIDTH-1:0] cycles;
`endif

    int checks;
    int fails;
    int done_count;

    gcd_top #(
        .WIDTH(WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Result(Result),
        .done  (done)
`ifdef GCD_CYCLE_COUNT_EN
        ,
        .cycles(cycles)
`endif
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and sample just after it, tallying done pulses
    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_count++;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
            $error("[TB] %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Launch one operation from IDLE and check the exact latency of its completion
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_res, input int n_steps,
                          input logic [WIDTH-1:0] prev_res);
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        done_count = 0;
        repeat (n_steps) tick();
        check("result_holds_before_done", Result, prev_res);
        check("done_low_during_calc", done, 1'b0);
        tick();
        check("result_at_completion", Result, exp_res);
        check("done_pulse", done, 1'b1);
`ifdef GCD_CYCLE_COUNT_EN
        check("cycle_count", cycles, n_steps + 1);
`endif
        tick();
        check("done_single_cycle", done, 1'b0);
        check("done_pulse_count", done_count, 1);
        check("result_holds_after_done", Result, exp_res);
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        done_count = 0;
        reset      = 1'b1;
        start      = 1'b0;
        A          = '0;
        B          = '0;

        // Reset state, then idle with start low
        tick();
        check("reset_result", Result, 0);
        check("reset_done", done, 1'b0);
`ifdef GCD_CYCLE_COUNT_EN
        check("reset_cycles", cycles, 0);
`endif
        reset      = 1'b0;
        done_count = 0;
        repeat (6) tick();
        check("idle_no_done", done_count, 0);
        check("idle_result", Result, 0);

        // Back-to-back operations with start held high
        $display("[TB] directed vectors with start held");
        run_op(8'd64, 8'd8, 8'd8, 7, 8'd0);
        run_op(8'd32, 8'd4, 8'd4, 7, 8'd8);
        run_op(8'd21, 8'd14, 8'd7, 2, 8'd4);
        run_op(8'd12, 8'd18, 8'd6, 2, 8'd7);
        run_op(8'd0, 8'd9, 8'd9, 0, 8'd6);
        run_op(8'd9, 8'd0, 8'd9, 0, 8'd9);
        run_op(8'd0, 8'd0, 8'd0, 0, 8'd9);
        run_op(8'd255, 8'd1, 8'd1, 254, 8'd0);

        // Operands changed during CALC must not affect the running operation
        $display("[TB] operand change mid-calc");
        A     = 8'd100;
        B     = 8'd75;
        tick();
        done_count = 0;
        tick();
        A = 8'd3;
        B = 8'd7;
        tick();
        tick();
        check("midcalc_hold", Result, 1);
        tick();
        check("midcalc_result", Result, 25);
        check("midcalc_done", done, 1'b1);
`ifdef GCD_CYCLE_COUNT_EN
        check("midcalc_cycles", cycles, 4);
`endif
        start = 1'b0;
        tick();
        check("midcalc_done_clear", done, 1'b0);

        // Reset during CALC aborts without publishing anything
        $display("[TB] reset mid-calc");
        A     = 8'd200;
        B     = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_result", Result, 0);
        check("abort_done", done, 1'b0);
`ifdef GCD_CYCLE_COUNT_EN
        check("abort_cycles", cycles, 0);
`endif
        reset      = 1'b0;
        done_count = 0;
        repeat (300) tick();
        check("abort_stays_idle_done", done_count, 0);
        check("abort_stays_idle_result", Result, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
